// File: rtl/univ_shift_reg_seq_if.sv
// Bus bundle for the universal shift register with burst sequencer.
// The master drives the controls and data. The slave (the register) drives the contents and status.
interface univ_shift_reg_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             ENABLE;
  logic [2:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             S_IN_L;
  logic             S_IN_R;
  logic             START;
  logic [CNT_W-1:0] COUNT;
  logic [WIDTH-1:0] Q;
  logic             S_OUT_L;
  logic             S_OUT_R;
  logic             BUSY;
  logic             DONE;

  modport master (
    output ENABLE, MODE, D, S_IN_L, S_IN_R, START, COUNT,
    input  Q, S_OUT_L, S_OUT_R, BUSY, DONE
  );

  modport slave (
    input  ENABLE, MODE, D, S_IN_L, S_IN_R, START, COUNT,
    output Q, S_OUT_L, S_OUT_R, BUSY, DONE
  );
endinterface

// File: rtl/univ_shift_reg_seq.sv
// Universal shift register with eight operations and a START/COUNT burst
// sequencer that runs an N-step shift on its own.
module univ_shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  univ_shift_reg_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHL  = 3'b001,
    OP_LOAD = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  state_t           state;
  op_t              lmode;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_ASR);
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (op)
      OP_SHL:  r = {cur[WIDTH-2:0], sl};
      OP_LOAD: r = din;
      OP_SHR:  r = {sr, cur[WIDTH-1:1]};
      OP_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ROR:  r = {cur[0], cur[WIDTH-1:1]};
      OP_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_CLR:  r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  // Register contents and sequencer state. Reset wins over everything, and ENABLE low freezes everything.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      q     <= '0;
      state <= IDLE;
      cnt   <= '0;
      lmode <= OP_HOLD;
    end else if (bus.ENABLE) begin
      case (state)
        IDLE: begin
          if (bus.START && is_shift(bus.MODE)) begin
            lmode <= op_t'(bus.MODE);
            cnt   <= bus.COUNT;
            state <= (bus.COUNT != '0) ? RUN : FIN;
          end else begin
            q <= apply_op(bus.MODE, q, bus.D, bus.S_IN_L, bus.S_IN_R);
          end
        end
        RUN: begin
          q   <= apply_op(lmode, q, bus.D, bus.S_IN_L, bus.S_IN_R);
          cnt <= cnt - 1'b1;
          if (cnt == {{(CNT_W-1){1'b0}}, 1'b1})
            state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Q       = q;
  assign bus.S_OUT_L = q[WIDTH-1];
  assign bus.S_OUT_R = q[0];
  assign bus.BUSY    = (state == RUN);
  assign bus.DONE    = (state == FIN);

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Directed bench for univ_shift_reg_seq: an 8-bit instance and a 16-bit/5-bit-count instance.
module tb_univ_shift_reg_seq;

  logic CLOCK;
  logic RESET;
  int   errors;
  int   checks;

  univ_shift_reg_seq_if #(.WIDTH(8),  .CNT_W(4)) b8  ();
  univ_shift_reg_seq_if #(.WIDTH(16), .CNT_W(5)) b16 ();

  univ_shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut8 (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (b8)
  );

  univ_shift_reg_seq #(.WIDTH(16), .CNT_W(5)) dut16 (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (b16)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks++; if (b8.Q !== 8'h00) begin $display("FAIL reset_q actual=%h required=%h", b8.Q, 8'h00); errors++; end
    checks++; if (b8.BUSY !== 1'b0) begin $display("FAIL reset_busy actual=%b required=0", b8.BUSY); errors++; end
    checks++; if (b8.DONE !== 1'b0) begin $display("FAIL reset_done actual=%b required=0", b8.DONE); errors++; end
    checks++; if (b16.Q !== 16'h0000) begin $display("FAIL reset_q16 actual=%h required=0000", b16.Q); errors++; end
  endtask

  task automatic test_direct();
    b8.MODE = 3'b010; b8.D = 8'hA5; step();
    checks++; if (b8.Q !== 8'hA5) begin $display("FAIL load actual=%h required=A5", b8.Q); errors++; end
    checks++; if ({b8.S_OUT_L, b8.S_OUT_R} !== 2'b11) begin $display("FAIL sout_a5 actual=%b required=11", {b8.S_OUT_L, b8.S_OUT_R}); errors++; end
    b8.MODE = 3'b001; b8.S_IN_L = 1'b1; step();
    checks++; if (b8.Q !== 8'h4B) begin $display("FAIL shl actual=%h required=4B", b8.Q); errors++; end
    checks++; if ({b8.S_OUT_L, b8.S_OUT_R} !== 2'b01) begin $display("FAIL sout_4b actual=%b required=01", {b8.S_OUT_L, b8.S_OUT_R}); errors++; end
    b8.MODE = 3'b000; step();
    checks++; if (b8.Q !== 8'h4B) begin $display("FAIL hold actual=%h required=4B", b8.Q); errors++; end
    b8.MODE = 3'b011; b8.S_IN_R = 1'b0; step();
    checks++; if (b8.Q !== 8'h25) begin $display("FAIL shr actual=%h required=25", b8.Q); errors++; end
    b8.MODE = 3'b111; step();
    checks++; if (b8.Q !== 8'h00) begin $display("FAIL clear actual=%h required=00", b8.Q); errors++; end
    b8.MODE = 3'b011; b8.S_IN_R = 1'b1; step();
    checks++; if (b8.Q !== 8'h80) begin $display("FAIL shr_sin1 actual=%h required=80", b8.Q); errors++; end
  endtask

  task automatic test_rotate_arith();
    b8.MODE = 3'b010; b8.D = 8'h81; step();
    b8.MODE = 3'b100; step();
    checks++; if (b8.Q !== 8'h03) begin $display("FAIL rol actual=%h required=03", b8.Q); errors++; end
    b8.MODE = 3'b010; step();
    b8.MODE = 3'b110; step();
    checks++; if (b8.Q !== 8'hC0) begin $display("FAIL asr1 actual=%h required=C0", b8.Q); errors++; end
    step();
    checks++; if (b8.Q !== 8'hE0) begin $display("FAIL asr2 actual=%h required=E0", b8.Q); errors++; end
    b8.MODE = 3'b010; step();
    b8.MODE = 3'b101; step();
    checks++; if (b8.Q !== 8'hC0) begin $display("FAIL ror actual=%h required=C0", b8.Q); errors++; end
    b8.MODE = 3'b000;
  endtask

  task automatic test_burst();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h2D; exp_q[1] = 8'h5A; exp_q[2] = 8'hB4;
    b8.MODE = 3'b010; b8.D = 8'h96; step();
    b8.MODE = 3'b100; b8.COUNT = 4'd3; b8.START = 1'b1; step();
    b8.START = 1'b0;
    checks++; if (b8.Q !== 8'h96) begin $display("FAIL burst_accept_q actual=%h required=96", b8.Q); errors++; end
    checks++; if (b8.BUSY !== 1'b1) begin $display("FAIL burst_accept_busy actual=%b required=1", b8.BUSY); errors++; end
    for (int i = 0; i < 3; i++) begin
      b8.MODE = (i % 2 == 0) ? 3'b010 : 3'b111;
      b8.D = 8'hFF;
      step();
      checks++; if (b8.Q !== exp_q[i]) begin $display("FAIL burst_q%0d actual=%h required=%h", i, b8.Q, exp_q[i]); errors++; end
      checks++; if (b8.BUSY !== (i < 2)) begin $display("FAIL burst_busy%0d actual=%b required=%b", i, b8.BUSY, (i < 2)); errors++; end
      checks++; if (b8.DONE !== (i == 2)) begin $display("FAIL burst_done%0d actual=%b required=%b", i, b8.DONE, (i == 2)); errors++; end
    end
    b8.MODE = 3'b000; step();
    checks++; if (b8.DONE !== 1'b0) begin $display("FAIL burst_done_pulse actual=%b required=0", b8.DONE); errors++; end
    checks++; if (b8.Q !== 8'hB4) begin $display("FAIL burst_final_q actual=%h required=B4", b8.Q); errors++; end
  endtask

  task automatic test_stall_zero();
    b8.MODE = 3'b010; b8.D = 8'h0F; step();
    b8.MODE = 3'b001; b8.S_IN_L = 1'b0; b8.COUNT = 4'd4; b8.START = 1'b1; step();
    b8.START = 1'b0;
    step();
    checks++; if (b8.Q !== 8'h1E) begin $display("FAIL stall_q1 actual=%h required=1E", b8.Q); errors++; end
    step();
    checks++; if (b8.Q !== 8'h3C) begin $display("FAIL stall_q2 actual=%h required=3C", b8.Q); errors++; end
    b8.ENABLE = 1'b0;
    step(); step();
    checks++; if (b8.Q !== 8'h3C) begin $display("FAIL stall_frozen actual=%h required=3C", b8.Q); errors++; end
    checks++; if (b8.BUSY !== 1'b1) begin $display("FAIL stall_busy actual=%b required=1", b8.BUSY); errors++; end
    b8.ENABLE = 1'b1;
    step();
    checks++; if (b8.Q !== 8'h78) begin $display("FAIL stall_q3 actual=%h required=78", b8.Q); errors++; end
    checks++; if (b8.DONE !== 1'b0) begin $display("FAIL stall_done_early actual=%b required=0", b8.DONE); errors++; end
    step();
    checks++; if (b8.Q !== 8'hF0) begin $display("FAIL stall_q4 actual=%h required=F0", b8.Q); errors++; end
    checks++; if ({b8.BUSY, b8.DONE} !== 2'b01) begin $display("FAIL stall_fin actual=%b required=01", {b8.BUSY, b8.DONE}); errors++; end
    b8.ENABLE = 1'b0; step();
    checks++; if (b8.DONE !== 1'b1) begin $display("FAIL done_held_stall actual=%b required=1", b8.DONE); errors++; end
    b8.ENABLE = 1'b1; step();
    checks++; if (b8.DONE !== 1'b0) begin $display("FAIL done_clear actual=%b required=0", b8.DONE); errors++; end
    b8.MODE = 3'b001; b8.COUNT = 4'd0; b8.START = 1'b1; step();
    b8.START = 1'b0; b8.MODE = 3'b000;
    checks++; if ({b8.BUSY, b8.DONE} !== 2'b01) begin $display("FAIL zero_cnt_status actual=%b required=01", {b8.BUSY, b8.DONE}); errors++; end
    checks++; if (b8.Q !== 8'hF0) begin $display("FAIL zero_cnt_q actual=%h required=F0", b8.Q); errors++; end
    step();
    checks++; if (b8.DONE !== 1'b0) begin $display("FAIL zero_cnt_done_end actual=%b required=0", b8.DONE); errors++; end
    b8.MODE = 3'b010; b8.D = 8'h11; b8.COUNT = 4'd3; b8.START = 1'b1; step();
    b8.START = 1'b0; b8.MODE = 3'b000;
    checks++; if ({b8.Q, b8.BUSY} !== {8'h11, 1'b0}) begin $display("FAIL start_nonshift actual=%h/%b required=11/0", b8.Q, b8.BUSY); errors++; end
  endtask

  task automatic test_reset_mid_burst();
    b8.MODE = 3'b010; b8.D = 8'h01; step();
    b8.MODE = 3'b100; b8.COUNT = 4'd15; b8.START = 1'b1; step();
    b8.START = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if ({b8.Q, b8.BUSY} !== {8'h10, 1'b1}) begin $display("FAIL mid_burst actual=%h/%b required=10/1", b8.Q, b8.BUSY); errors++; end
    RESET = 1'b1; step();
    RESET = 1'b0;
    checks++; if ({b8.Q, b8.BUSY, b8.DONE} !== {8'h00, 2'b00}) begin $display("FAIL abort actual=%h/%b/%b required=00/0/0", b8.Q, b8.BUSY, b8.DONE); errors++; end
    b8.MODE = 3'b010; b8.D = 8'h3C; step();
    checks++; if ({b8.Q, b8.BUSY} !== {8'h3C, 1'b0}) begin $display("FAIL load_after_abort actual=%h/%b required=3C/0", b8.Q, b8.BUSY); errors++; end
    b8.MODE = 3'b000;
  endtask

  task automatic test_parametric();
    b16.MODE = 3'b010; b16.D = 16'h8001; step();
    b16.MODE = 3'b110; b16.COUNT = 5'd20; b16.START = 1'b1; step();
    b16.START = 1'b0; b16.MODE = 3'b000;
    for (int i = 0; i < 19; i++) step();
    checks++; if (b16.BUSY !== 1'b1) begin $display("FAIL p_asr_busy actual=%b required=1", b16.BUSY); errors++; end
    step();
    checks++; if ({b16.Q, b16.DONE} !== {16'hFFFF, 1'b1}) begin $display("FAIL p_asr20 actual=%h/%b required=FFFF/1", b16.Q, b16.DONE); errors++; end
    step();
    b16.MODE = 3'b010; b16.D = 16'h1234; step();
    b16.MODE = 3'b101; b16.COUNT = 5'd16; b16.START = 1'b1; step();
    b16.START = 1'b0; b16.MODE = 3'b000;
    for (int i = 0; i < 4; i++) step();
    checks++; if (b16.Q !== 16'h4123) begin $display("FAIL p_ror4 actual=%h required=4123", b16.Q); errors++; end
    for (int i = 0; i < 12; i++) step();
    checks++; if ({b16.Q, b16.DONE} !== {16'h1234, 1'b1}) begin $display("FAIL p_ror16 actual=%h/%b required=1234/1", b16.Q, b16.DONE); errors++; end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RESET = 1'b1;
    b8.ENABLE = 1'b1; b8.MODE = 3'b000; b8.D = '0; b8.S_IN_L = 1'b0;
    b8.S_IN_R = 1'b0; b8.START = 1'b0; b8.COUNT = '0;
    b16.ENABLE = 1'b1; b16.MODE = 3'b000; b16.D = '0; b16.S_IN_L = 1'b0;
    b16.S_IN_R = 1'b0; b16.START = 1'b0; b16.COUNT = '0;
    test_reset();
    test_direct();
    test_rotate_arith();
    test_burst();
    test_stall_zero();
    test_reset_mid_burst();
    test_parametric();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_seq.md
Name: univ_shift_reg_seq

Overview:
Parametrised universal shift register with an added burst sequencer. It supports eight register operations: hold, load, clear, logical shifts, rotates and arithmetic shift right. A START/COUNT handshake runs an N-step shift autonomously, with BUSY/DONE status. It is the general-width replacement for the fixed 8-bit 4-mode register and feeds serial links and bit-serial datapaths in the same design.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst COUNT; max burst = 2^CNT_W-1 shifts

Ports:
CLOCK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
ENABLE  in  1  clock enable for register and sequencer; low = full stall
MODE  in  3  operation select (see Behaviour)
D  in  WIDTH  parallel load data
S_IN_L  in  1  serial in, enters at bit 0 on shift-left
S_IN_R  in  1  serial in, enters at bit WIDTH-1 on logical shift-right
START  in  1  burst request (level sampled, IDLE only)
COUNT  in  CNT_W  number of shifts for burst
Q  out  WIDTH  register contents
S_OUT_L  out  1  Q[WIDTH-1]
S_OUT_R  out  1  Q[0]
BUSY  out  1  high while burst in progress
DONE  out  1  one-cycle pulse after burst completes

Behaviour:
- Reset: Q=0, state IDLE, BUSY=0, DONE=0, internal count=0, latched mode=000. Reset has priority over ENABLE and overrides any state, including an active burst, which is aborted.
- MODE encoding (operation applied per active edge):
  - 000 hold
  - 001 shift left: Q <= {Q[W-2:0], S_IN_L}
  - 010 load: Q <= D
  - 011 logical shift right: Q <= {S_IN_R, Q[W-1:1]}
  - 100 rotate left: Q <= {Q[W-2:0], Q[W-1]}
  - 101 rotate right: Q <= {Q[0], Q[W-1:1]}
  - 110 arithmetic shift right: Q <= {Q[W-1], Q[W-1:1]}
  - 111 clear: Q <= 0
- Shift-type modes: 001, 011, 100, 101, 110.
- ENABLE=0: Q, state, count and latched mode all frozen. START is ignored. DONE, if high, stays high until the next enabled edge.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - If START=1 and MODE is a shift-type mode: latch MODE and COUNT, Q unchanged at this edge.
    - COUNT>0 -> RUN
    - COUNT=0 -> FIN, no shift
  - Otherwise MODE is applied directly to Q (START with a non-shift mode is ignored; the op executes directly).
- RUN:
  - Each enabled edge applies the latched mode and decrements count.
  - On the edge where count goes 1->0 (the last shift): -> FIN.
  - MODE, D and START are ignored. S_IN_L/S_IN_R are sampled live on every shift.
- FIN: Q held, START ignored; next enabled edge -> IDLE.
- Outputs: BUSY = (state==RUN). DONE = (state==FIN). Both are registered state decodes with no combinational path from inputs.
- Latency: a burst of N>0 accepted at edge k finishes its shifts at edges k+1..k+N (ENABLE continuously high), so DONE is high in the cycle after edge k+N. A new START is accepted no earlier than edge k+N+2.
- Width rules:
  - COUNT is unsigned.
  - Rotate by WIDTH returns the original value.
  - Shifting by >=WIDTH fully replaces Q with serial-in bits (logical) or sign bits (arithmetic).
- S_OUT_L/S_OUT_R are combinational decodes of Q.

Test Plan:
1. Reset/direct ops, WIDTH=8: RESET 1 cycle -> Q=00, BUSY=0, DONE=0. Then:
   - MODE=010, D=A5 -> Q=A5
   - MODE=001, S_IN_L=1 -> Q=4B
   - MODE=011, S_IN_R=0 -> Q=25
   - MODE=111 -> Q=00
2. Rotate/arith: load 81.
   - MODE=100 one edge -> Q=03
   - reload 81, MODE=110 -> Q=C0, then again -> Q=E0
   - reload 81, MODE=101 -> Q=C0
3. Burst: load 96, START=1, MODE=100, COUNT=3 -> BUSY high 3 cycles, Q sequence 2D,5A,B4. DONE is a single pulse the next cycle. MODE toggling during RUN has no effect.
4. Stall and zero count:
   - Burst MODE=001, COUNT=4, S_IN_L=0, ENABLE low for 2 cycles mid-burst -> exactly 4 shifts total, Q frozen while low, DONE delayed 2 cycles.
   - START with COUNT=0 -> no BUSY, DONE pulse next cycle, Q unchanged.
5. Reset mid-burst: COUNT=15 rotate, RESET on 5th RUN cycle -> next cycle Q=00, BUSY=0, DONE=0, IDLE. A following direct load of 3C works immediately.
6. Parametric: WIDTH=16, CNT_W=5. Load 8001, burst MODE=110, COUNT=20 -> Q=FFFF. Burst MODE=101, COUNT=16 on 1234 -> Q=1234.
